ofmaps_writeback_ctrl: RTL and testbench

OFMAPS_WRITEBACK_CTRL -- requirements
Module: ofmaps_writeback_ctrl

---
 rtl/ofmaps_writeback_ctrl.sv | 93 +++++++++
 tb/tb_ofmaps_writeback_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ofmaps_writeback_ctrl.sv
// ofmaps_writeback_ctrl: streams one output frame of MAC-array results through a 2-entry skid buffer onto AXI-Stream,
// tracking channel/column/row position to mark row ends and frame completion.
module ofmaps_writeback_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [11:0]           ofmaps_channel,
    input  logic [8:0]            ofmaps_width,
    input  logic                  psum_valid,
    input  logic [DATA_WIDTH-1:0] psum_data,
    output logic                  psum_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [11:0]           cfg_ch, ch_cnt;
    logic [8:0]            cfg_w, col_cnt, row_cnt;
    logic [29:0]           in_remaining;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            fifo_count;
    logic                  start_acc, push, pop, ch_wrap, col_wrap, final_word, zero_cfg;

    assign start_acc     = (state == IDLE) && start;
    assign zero_cfg      = (ofmaps_channel == 12'd0) || (ofmaps_width == 9'd0);
    assign psum_ready    = (state == RUN) && (fifo_count < 2'(FIFO_DEPTH)) && (in_remaining != 30'd0);
    assign push          = psum_valid & psum_ready;
    assign m_axis_tvalid = fifo_count != 2'd0;
    assign m_axis_tdata  = mem[rd_ptr];
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign ch_wrap       = ch_cnt == cfg_ch - 12'd1;
    assign col_wrap      = col_cnt == cfg_w - 9'd1;
    assign m_axis_tlast  = m_axis_tvalid & ch_wrap & col_wrap;
    assign final_word    = pop & m_axis_tlast & (row_cnt == cfg_w - 9'd1);
    assign busy          = state == RUN;
    assign done          = state == DONE;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? (zero_cfg ? DONE : RUN) : IDLE) :
                   (state == RUN)  ? (final_word ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cfg_ch       <= '0;
            cfg_w        <= '0;
            in_remaining <= '0;
            ch_cnt       <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                cfg_ch       <= ofmaps_channel;
                cfg_w        <= ofmaps_width;
                in_remaining <= 30'(ofmaps_channel) * 30'(ofmaps_width) * 30'(ofmaps_width);
                ch_cnt       <= '0;
                col_cnt      <= '0;
                row_cnt      <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr]  <= psum_data;
                    wr_ptr       <= ~wr_ptr;
                    in_remaining <= in_remaining - 30'd1;
                end
                // position counters follow the output side so tlast tags the word actually on the bus
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                    ch_cnt <= ch_wrap ? 12'd0 : ch_cnt + 12'd1;
                    if (ch_wrap) begin
                        col_cnt <= col_wrap ? 9'd0 : col_cnt + 9'd1;
                        if (col_wrap) row_cnt <= row_cnt + 9'd1;
                    end
                end
                fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_ofmaps_writeback_ctrl.sv
// tb_ofmaps_writeback_ctrl: directed checks of frame streaming, backpressure, zero config, overrun, restart and reset.
module tb_ofmaps_writeback_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, psum_valid, psum_ready, m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, done;
    logic [11:0] ofmaps_channel;
    logic [8:0]  ofmaps_width;
    logic [31:0] psum_data, m_axis_tdata;
    int          checks = 0, errors = 0;
    int          n_out, n_acc, done_cnt;
    logic [31:0] out_q [64];
    logic        last_q [64];
    logic        rdy_q [64], tv_q [64], dn_q [64];
    logic [31:0] td_q [64];

    ofmaps_writeback_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ofmaps_channel(ofmaps_channel),
        .ofmaps_width(ofmaps_width), .psum_valid(psum_valid), .psum_data(psum_data),
        .psum_ready(psum_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [11:0] ch, input logic [8:0] w);
        start = 1'b1;
        ofmaps_channel = ch;
        ofmaps_width = w;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // offers words 1..limit, samples outputs at the falling edge, drives inputs just after the rising edge
    task automatic run(input int cycles, input int limit, input int stall_until, input int start_at);
        logic acc;
        n_out = 0; n_acc = 0; done_cnt = 0;
        psum_data = 32'd1;
        psum_valid = limit > 0;
        for (int c = 0; c < cycles; c++) begin
            m_axis_tready = c >= stall_until;
            start = c == start_at;
            if (c == start_at) ofmaps_channel = 12'd9;
            @(negedge clk);
            rdy_q[c] = psum_ready; tv_q[c] = m_axis_tvalid; td_q[c] = m_axis_tdata; dn_q[c] = done;
            if (done) done_cnt++;
            acc = psum_valid & psum_ready;
            if (m_axis_tvalid && m_axis_tready && n_out < 64) begin
                out_q[n_out] = m_axis_tdata;
                last_q[n_out] = m_axis_tlast;
                n_out++;
            end
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                psum_data++;
                if (n_acc >= limit) psum_valid = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; psum_valid = 1'b0; psum_data = '0; m_axis_tready = 1'b0;
        ofmaps_channel = '0; ofmaps_width = '0;
        #12;
        chk("rst_ready", psum_ready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_start(12'd2, 9'd2);
        run(14, 8, 0, -1);
        chk("t1_nout", n_out, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_data%0d", i), out_q[i], i + 1);
            chk($sformatf("t1_last%0d", i), last_q[i], (i == 3 || i == 7) ? 1 : 0);
        end
        chk("t1_stream_c8", tv_q[8], 1);
        chk("t1_done_c8", dn_q[8], 0);
        chk("t1_done_c9", dn_q[9], 1);
        chk("t1_done_cnt", done_cnt, 1);

        do_start(12'd3, 9'd1);
        run(16, 3, 6, -1);
        chk("t2_rdy_c0", rdy_q[0], 1);
        chk("t2_rdy_c1", rdy_q[1], 1);
        for (int c = 2; c < 6; c++) chk($sformatf("t2_rdy_c%0d", c), rdy_q[c], 0);
        for (int c = 1; c < 6; c++) begin
            chk($sformatf("t2_tv_c%0d", c), tv_q[c], 1);
            chk($sformatf("t2_td_c%0d", c), td_q[c], 1);
        end
        chk("t2_nout", n_out, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_data%0d", i), out_q[i], i + 1);
        chk("t2_last0", last_q[0], 0);
        chk("t2_last2", last_q[2], 1);
        chk("t2_done_cnt", done_cnt, 1);

        do_start(12'd0, 9'd4);
        run(4, 5, 0, -1);
        chk("t3_done_c0", dn_q[0], 1);
        chk("t3_done_c1", dn_q[1], 0);
        chk("t3_acc", n_acc, 0);
        chk("t3_nout", n_out, 0);
        chk("t3_done_cnt", done_cnt, 1);

        do_start(12'd4, 9'd2);
        run(30, 20, 0, -1);
        chk("t4_acc", n_acc, 16);
        chk("t4_nout", n_out, 16);
        chk("t4_rdy_c15", rdy_q[15], 1);
        chk("t4_rdy_c16", rdy_q[16], 0);
        chk("t4_data15", out_q[15], 16);
        chk("t4_last3", last_q[3], 0);
        chk("t4_last7", last_q[7], 1);
        chk("t4_last15", last_q[15], 1);
        chk("t4_done_cnt", done_cnt, 1);
        psum_valid = 1'b0;

        do_start(12'd2, 9'd2);
        run(16, 8, 0, 3);
        chk("t5_nout", n_out, 8);
        chk("t5_last1", last_q[1], 0);
        chk("t5_last3", last_q[3], 1);
        chk("t5_last7", last_q[7], 1);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_busy_end", busy, 0);

        do_start(12'd2, 9'd2);
        run(4, 8, 0, -1);
        chk("t6_nout_pre", n_out, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", psum_ready, 0);
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_tlast", m_axis_tlast, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_tdata", m_axis_tdata, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(12'd1, 9'd2);
        run(10, 4, 0, -1);
        chk("t6_nout", n_out, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_data%0d", i), out_q[i], i + 1);
            chk($sformatf("t6_last%0d", i), last_q[i], (i == 1 || i == 3) ? 1 : 0);
        end
        chk("t6_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
